// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate type and RGB332 colour expansion.
package vga_pkg;

  // Default 640x480@60 Hz timing (pixel clock 25 MHz).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_MUX_LAT  = 1;

  localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int COORD_W = 11;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Replicate each channel's bits so that all-ones maps to 8'hFF and zero to 8'h00.
  function automatic rgb888_t rgb332_expand(input logic [7:0] pix);
    rgb888_t c;
    c.r = {pix[7:5], pix[7:5], pix[7:6]};
    c.g = {pix[4:2], pix[4:2], pix[4:3]};
    c.b = {4{pix[1:0]}};
    return c;
  endfunction

endpackage

// File: rtl/vga_if.sv
// Pixel-side bus between the timing generator, the object mux and the DAC pins.
interface vga_if;
  import vga_pkg::*;

  coord_t     pixelX;
  coord_t     pixelY;
  logic       startOfFrame;
  logic [7:0] RGBIn;
  logic [7:0] red;
  logic [7:0] green;
  logic [7:0] blue;
  logic       hsync;
  logic       vsync;
  logic       blank_n;
  logic       sync_n;

  // Timing generator side: publishes coordinates and drives the DAC.
  modport master (
    output pixelX, pixelY, startOfFrame,
    output red, green, blue, hsync, vsync, blank_n, sync_n,
    input  RGBIn
  );

  // Object mux / board side: consumes coordinates and pins, returns the pixel.
  modport slave (
    input  pixelX, pixelY, startOfFrame,
    input  red, green, blue, hsync, vsync, blank_n, sync_n,
    output RGBIn
  );

endinterface

// File: rtl/vga_sync_delay_line.sv
// Fixed-depth register pipeline used to align sync/active terms with the mux pixel.
module sync_delay_line #(
  parameter int               DEPTH     = 1,
  parameter int               WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ resetN;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // Shift the terms one stage per clock; every stage starts from RESET_VAL.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        // NOTE: these stages are plain flops, not RAM, so resetting every entry is cheap and keeps idle syncs inactive.
        for (int i = 0; i < DEPTH; i++) stage[i] <= RESET_VAL;
      end else begin
        stage[0] <= din;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_out.sv
// VGA timing generator: publishes pixelX/pixelY to the object mux and drives the
// DAC with the returned RGB332 pixel expanded to 8 bits per channel.
module vga_timing_out
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int MUX_LAT  = DEF_MUX_LAT
) (
  input  logic  clk,
  input  logic  resetN,
  vga_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS      = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS      = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_ON  = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_OFF = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_SYNC_ON  = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_OFF = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line bit order is {hs, vs, active}; idle state is syncs high, not visible.
  localparam logic [2:0] TERMS_RESET = 3'b110;

  coord_t     hcnt;
  coord_t     vcnt;
  logic       hs_raw;
  logic       vs_raw;
  logic       active_raw;
  logic [2:0] terms_dly;
  logic       hs_dly;
  logic       vs_dly;
  logic       active_dly;
  rgb888_t    rgb_q;
  logic       hsync_q;
  logic       vsync_q;
  logic       blank_q;

  // Pixel and line counters; the line counter advances only on the pixel wrap.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hcnt <= '0;
      vcnt <= '0;
    end else if (hcnt == H_LAST) begin
      // NOTE: non-blocking so both counters update from the same pre-edge values.
      hcnt <= '0;
      vcnt <= (vcnt == V_LAST) ? '0 : vcnt + coord_t'(1);
    end else begin
      hcnt <= hcnt + coord_t'(1);
    end
  end

  // Undelayed sync and visible-area terms decoded from the counters.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    hs_raw     = 1'b1;
    vs_raw     = 1'b1;
    active_raw = 1'b0;
    if (hcnt >= H_SYNC_ON && hcnt < H_SYNC_OFF) hs_raw = 1'b0;
    if (vcnt >= V_SYNC_ON && vcnt < V_SYNC_OFF) vs_raw = 1'b0;
    if (hcnt < H_VIS && vcnt < V_VIS) active_raw = 1'b1;
  end

  sync_delay_line #(
    .DEPTH     (MUX_LAT),
    .WIDTH     (3),
    .RESET_VAL (TERMS_RESET)
  ) u_sync_dly (
    .clk    (clk),
    .resetN (resetN),
    .din    ({hs_raw, vs_raw, active_raw}),
    .dout   (terms_dly)
  );

  assign {hs_dly, vs_dly, active_dly} = terms_dly;

  // Output register: sample the mux pixel alongside its delayed sync/blank terms.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      blank_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hsync_q <= hs_dly;
      vsync_q <= vs_dly;
      blank_q <= active_dly;
      rgb_q   <= active_dly ? rgb332_expand(vga.RGBIn) : '0;
    end
  end

  assign vga.pixelX       = hcnt;
  assign vga.pixelY       = vcnt;
  assign vga.startOfFrame = (hcnt == '0) && (vcnt == '0);
  assign vga.red          = rgb_q.r;
  assign vga.green        = rgb_q.g;
  assign vga.blue         = rgb_q.b;
  assign vga.hsync        = hsync_q;
  assign vga.vsync        = vsync_q;
  assign vga.blank_n      = blank_q;
  assign vga.sync_n       = 1'b1;

endmodule

// File: doc/vga_timing_out.md
# vga_timing_out

- Generates 640x480@60 Hz VGA timing and publishes the current pixel coordinate to the object/mux layer.
- Takes back the registered RGB332 pixel that the object mux returns for that coordinate, expands it to 8 bits per channel and drives the DAC with sync and blank aligned to it.
- Sits between the object mux and the board VGA DAC. It is the source of pixelX/pixelY and the sink of RGBOut.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- MUX_LAT, 1, clocks from pixelX/pixelY to a valid RGBIn (range 0..7)

Ports:
- clk  in  1  pixel clock, 25 MHz. Reset resetN, asynchronous, active-low; clock clk.
- resetN  in  1  asynchronous active-low reset
- RGBIn  in  8  pixel from the object mux, RGB332: [7:5]=R, [4:2]=G, [1:0]=B
- pixelX  out  11  current horizontal counter, 0..H_TOTAL-1
- pixelY  out  11  current vertical counter, 0..V_TOTAL-1
- startOfFrame  out  1  high while pixelX==0 and pixelY==0
- red, green, blue  out  8 each  DAC colour
- hsync, vsync  out  1 each  active-low syncs
- blank_n  out  1  low outside the visible area
- sync_n  out  1  constant 1 (composite sync unused)

## Operation
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Horizontal counter: hcnt increments every clock and wraps from H_TOTAL-1 to 0.
- Vertical counter: vcnt increments only on the hcnt wrap, and wraps from V_TOTAL-1 to 0.
- pixelX = hcnt and pixelY = vcnt, driven directly from the counter registers.
- Raw (undelayed) sync and active terms:
  - active = hcnt < H_ACTIVE and vcnt < V_ACTIVE.
  - hs_raw is low for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vs_raw is low for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (490..491).
- hs_raw, vs_raw and active pass through a delay line of MUX_LAT stages, so they line up with RGBIn.
- Output register (one stage):
  - hsync, vsync and blank_n take the delayed terms.
  - red/green/blue take the expanded RGBIn when the delayed active is 1, and 0 otherwise.
- Colour expansion:
  - red = {R,R,R[2:1]}
  - green = {G,G,G[2:1]}
  - blue = {B,B,B,B}
  - The result is full-scale: R=3'b111 gives 8'hFF, R=0 gives 8'h00.
- Reset values:
  - hcnt = 0, vcnt = 0.
  - All delay-line stages: sync terms 1, active 0.
  - hsync = 1, vsync = 1, blank_n = 0, red/green/blue = 0, sync_n = 1.
- Reset asserted mid-frame: everything returns to the reset values immediately (asynchronously). After release, counting restarts at (0,0) and startOfFrame is high in the first cycle.

## Timing
- Counter-to-output latency is MUX_LAT+1 clocks. A coordinate presented at cycle t appears on the pins, with its colour, sync and blank, at t+MUX_LAT+1.
- With MUX_LAT=1: pixel (0,0) is presented in cycle 0 after reset and blank_n first rises in cycle 2.
- Line period is 800 clocks; frame period is 420000 clocks.
- blank_n is high for exactly 640 consecutive clocks per visible line and is low for the whole of lines 480..524.
- hsync is low for 96 clocks per line on every line, including blanked lines.
- vsync is low for 2 full lines; its edges coincide with hcnt=0 boundaries, after the same MUX_LAT+1 delay.
- The end-of-line and end-of-frame wrap at (799,524) → (0,0) completes in one clock. startOfFrame is asserted for exactly 1 clock per frame.
- RGBIn is sampled only in the output-register clock. RGBIn during blanking is ignored.

## Structure
- Package vga_pkg holds:
  - the default timing constants;
  - the derived H_TOTAL and V_TOTAL;
  - the coordinate width (11);
  - the function rgb332_expand.
- Sub-module sync_delay_line handles the delay:
  - parameters DEPTH and WIDTH, with DEPTH=0 meaning a pass-through;
  - asynchronous reset to a parameter RESET_VAL;
  - instantiated once, 3 bits wide: {hs, vs, active}.
- Counter and output logic live in vga_timing_out.

## Test plan
- Release reset with RGBIn held at 8'hFF: pixelX/pixelY start at (0,0) with startOfFrame=1. In cycle 2, blank_n=1 and red=green=blue=8'hFF. The first blank_n fall occurs at cycle 642.
- Run one full frame: count exactly 480 lines containing 640 blank_n-high clocks each, 525 hsync pulses of 96 clocks each, one vsync pulse of 1600 clocks, and one startOfFrame pulse.
- Drive RGBIn = pixelX[7:0] through a 1-cycle register model. At output pixel x=5, red/green/blue equal the expansion of 8'h05: red=0, green=8'h24, blue=8'h55. With the mux delay mismatched, the bench detects the shift.
- Hold RGBIn = 8'hE0 during blanking: red/green/blue stay 0 whenever blank_n=0.
- Pulse resetN low at hcnt=300, vcnt=200: outputs take the reset values within the same cycle, and counting restarts from (0,0) after release.
- Elaborate with MUX_LAT=0 and MUX_LAT=3: the first blank_n rise lands at cycle 1 and cycle 4 respectively.
